// File: rtl/adc_moving_avg.sv
// Boxcar moving-average filter for the ADC sample stream. It keeps the last
// 2^LOG2_WIN samples with a running sum and sends out a truncated mean over valid/ready.
module adc_moving_avg #(
  parameter int DATA_W   = 16,
  parameter int LOG2_WIN = 3,
  parameter int OVR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              clear,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              primed,
  output logic [OVR_W-1:0]  overrun_cnt
);
  localparam int WIN    = 1 << LOG2_WIN;
  localparam int SUM_W  = DATA_W + LOG2_WIN;
  localparam int FILL_W = LOG2_WIN + 1;

  logic [WIN-1:0][DATA_W-1:0] win_buf;
  logic [LOG2_WIN-1:0]        wptr;
  logic [FILL_W-1:0]          fill;
  logic [SUM_W-1:0]           sum, sum_new;
  logic [DATA_W-1:0]          result;
  logic                       new_res, take;

  // The buffer slot at wptr holds the oldest sample. That sample leaves the window as in_data enters.
  assign sum_new = sum + SUM_W'(in_data) - SUM_W'(win_buf[wptr]);
  assign result  = sum_new[SUM_W-1:LOG2_WIN];
  assign new_res = in_valid && (fill >= FILL_W'(WIN - 1));
  assign take    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_buf     <= '0;
      wptr        <= '0;
      fill        <= '0;
      sum         <= '0;
      primed      <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      overrun_cnt <= '0;
    end else if (clear) begin
      win_buf     <= '0;
      wptr        <= '0;
      fill        <= '0;
      sum         <= '0;
      primed      <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (in_valid) begin
        win_buf[wptr] <= in_data;
        wptr          <= wptr + 1'b1;
        sum           <= sum_new;
        if (fill != FILL_W'(WIN))
          fill <= fill + 1'b1;
      end
      if (new_res) begin
        primed    <= 1'b1;
        out_data  <= result;
        out_valid <= 1'b1;
        // A result that was never taken is replaced by a newer one. Count this as an overrun.
        if (out_valid && !out_ready && (overrun_cnt != '1))
          overrun_cnt <= overrun_cnt + 1'b1;
      end else if (take) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adc_moving_avg.sv
// Directed bench for adc_moving_avg. A queue-based window model is checked on
// every cycle, and literal expectations pin the model at key points.
module tb_adc_moving_avg;
  localparam int DATA_W   = 16;
  localparam int LOG2_WIN = 3;
  localparam int OVR_W    = 8;
  localparam int WIN      = 1 << LOG2_WIN;
  localparam int OVR_MAX  = (1 << OVR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              clear = 1'b0;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              primed;
  logic [OVR_W-1:0]  overrun_cnt;

  int checks = 0;
  int errors = 0;

  adc_moving_avg #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN), .OVR_W(OVR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .clear(clear),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .primed(primed), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // The model is the plain definition: the mean of the last WIN samples, produced
  // once WIN samples exist, followed by the output-register rules.
  int          hist[$];
  int unsigned m_data;
  bit          m_valid, m_primed, m_new;
  int          m_ovr;
  longint      m_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      hist.delete();
      m_data = 0; m_valid = 0; m_primed = 0; m_ovr = 0;
    end else begin
      m_new = 0;
      if (in_valid) begin
        hist.push_back(int'(in_data));
        if (hist.size() > WIN) void'(hist.pop_front());
        if (hist.size() == WIN) begin
          m_sum = 0;
          foreach (hist[i]) m_sum += hist[i];
          m_new = 1;
          m_primed = 1;
        end
      end
      if (m_new) begin
        if (m_valid && !out_ready && m_ovr < OVR_MAX) m_ovr++;
        m_data  = int'(m_sum / WIN);
        m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    chk("out_valid", out_valid, m_valid);
    chk("primed", primed, m_primed);
    chk("overrun_cnt", overrun_cnt, m_ovr);
    if (m_valid) chk("out_data", out_data, m_data);
  end

  // Apply one cycle of inputs. The task returns at the following negedge, once the edge has taken effect.
  task automatic step(input bit v, input int d, input bit rdy, input bit clr);
    in_valid  = v;
    in_data   = DATA_W'(d);
    out_ready = rdy;
    clear     = clr;
    @(negedge clk);
    in_valid = 0;
    clear    = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset primed", primed, 0);
    chk("reset overrun", overrun_cnt, 0);
    rst_n = 1;
    step(0, 0, 1, 0);

    // Constant 100: no output until the 8th sample.
    for (int i = 0; i < 7; i++) step(1, 100, 1, 0);
    chk("const100 pre-window valid", out_valid, 0);
    chk("const100 pre-window primed", primed, 0);
    step(1, 100, 1, 0);
    chk("const100 valid", out_valid, 1);
    chk("const100 data", out_data, 100);
    chk("const100 primed", primed, 1);
    step(0, 0, 1, 0);
    chk("const100 consumed", out_valid, 0);

    // Ramp 1..9 wraps wptr.
    step(0, 0, 1, 1);
    for (int i = 1; i <= 8; i++) step(1, i, 1, 0);
    chk("ramp s8", out_data, 4);
    step(1, 9, 1, 0);
    chk("ramp s9", out_data, 5);

    // Full-scale samples must not overflow the sum.
    step(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 'hFFFF, 1, 0);
    chk("fullscale s8", out_data, 'hFFFF);
    step(1, 'hFFFF, 1, 0);
    chk("fullscale s9", out_data, 'hFFFF);

    // Stalled consumer: two overwrites.
    step(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 8, 1, 0);
    step(0, 0, 1, 0);
    chk("stall start empty", out_valid, 0);
    step(1, 8, 0, 0);
    step(1, 16, 0, 0);
    step(0, 0, 0, 0);
    chk("stall held data", out_data, 9);
    step(1, 24, 0, 0);
    chk("stall data", out_data, 11);
    chk("stall overrun", overrun_cnt, 2);
    step(0, 0, 1, 0);
    chk("stall drained", out_valid, 0);
    chk("stall data held", out_data, 11);

    // A new result and a take in the same cycle: load the result, no overrun.
    step(1, 32, 0, 0);
    chk("take+new first", out_data, 14);
    step(1, 40, 1, 0);
    chk("take+new data", out_data, 18);
    chk("take+new valid", out_valid, 1);
    chk("take+new overrun", overrun_cnt, 2);

    // The overrun counter saturates.
    for (int i = 0; i < OVR_MAX + 5; i++) step(1, 7, 0, 0);
    chk("overrun saturated", overrun_cnt, OVR_MAX);

    // clear wins over a simultaneous sample. An async reset mid-window then drops the history.
    step(1, 500, 1, 1);
    chk("clear valid", out_valid, 0);
    chk("clear primed", primed, 0);
    chk("clear overrun", overrun_cnt, 0);
    for (int i = 0; i < 4; i++) step(1, 200, 1, 0);
    #2 rst_n = 0;
    @(negedge clk);
    chk("async reset primed", primed, 0);
    rst_n = 1;
    for (int i = 0; i < 7; i++) step(1, 50, 1, 0);
    chk("refill no output", out_valid, 0);
    step(1, 50, 1, 0);
    chk("refill valid", out_valid, 1);
    chk("refill data", out_data, 50);
    step(0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
